// File: rtl/video_pkg.sv
// Shared definitions for the AXI4-Stream video pattern generator.
// Holds the pattern select codes, the FSM state encoding and the
// colour-bar palette (RGB888: R[23:16], G[15:8], B[7:0]).
package video_pkg;

    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_CHECKER = 2'd1,
        PAT_RAMP    = 2'd2,
        PAT_GRID    = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_LINE_GAP  = 2'd2,
        ST_FRAME_GAP = 2'd3
    } state_e;

    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_BLACK   = 24'h000000;

    // Bars run left to right in the classic SMPTE-like order.
    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = RGB_WHITE;
            3'd1:    rgb = RGB_YELLOW;
            3'd2:    rgb = RGB_CYAN;
            3'd3:    rgb = RGB_GREEN;
            3'd4:    rgb = RGB_MAGENTA;
            3'd5:    rgb = RGB_RED;
            3'd6:    rgb = RGB_BLUE;
            default: rgb = RGB_BLACK;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/axis_video_pattern_gen_if.sv
// AXI4-Stream video bus bundle.
// Signals: tdata (pixel), tvalid, tlast (end of line), tuser (start of
// frame), tready (downstream backpressure).
interface axis_video_pattern_gen_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tuser;
    logic                  tready;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_video_pattern_gen_pixel.sv
// pattern_pixel: purely combinational colour lookup for one pixel.
// Ports: i_x/i_y pixel coordinate, i_sel pattern code, o_rgb RGB888 pixel.
module pattern_pixel
    import video_pkg::*;
#(
    parameter int WIDTH       = 1920,
    parameter int HEIGHT      = 1080,
    parameter int COORD_WIDTH = 16
) (
    input  logic [COORD_WIDTH-1:0] i_x,
    input  logic [COORD_WIDTH-1:0] i_y,
    input  pattern_e               i_sel,
    output logic [23:0]            o_rgb
);

    // Guard against lines narrower than eight pixels.
    localparam int                     BAR_W  = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;
    localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(HEIGHT - 1);

    logic [COORD_WIDTH-1:0] w_bar;
    logic [2:0]             w_bar_idx;
    logic                   w_grid_on;

    assign w_bar     = i_x / COORD_WIDTH'(BAR_W);
    // Widths not divisible by 8 leave a remainder that would index bar 8+.
    assign w_bar_idx = (w_bar > COORD_WIDTH'(7)) ? 3'd7 : w_bar[2:0];
    assign w_grid_on = (i_x[4:0] == 5'd0) || (i_y[4:0] == 5'd0) ||
                       (i_x == X_LAST) || (i_y == Y_LAST);

    always_comb begin
        o_rgb = RGB_BLACK;
        case (i_sel)
            PAT_BARS:    o_rgb = bar_colour(w_bar_idx);
            PAT_CHECKER: o_rgb = (i_x[4] ^ i_y[4]) ? RGB_WHITE : RGB_BLACK;
            PAT_RAMP:    o_rgb = {i_x[7:0], i_x[7:0], i_x[7:0]};
            PAT_GRID:    o_rgb = w_grid_on ? RGB_WHITE : RGB_BLACK;
            default:     o_rgb = RGB_BLACK;
        endcase
    end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// axis_video_pattern_gen: AXI4-Stream test-pattern source.
// Ports: clk, rst_n (async active-low), enable (run continuously),
// pattern_sel (latched at frame start), m_axis (master stream),
// frame_done (1-cycle pulse on final beat), frame_count (wrapping).
//
// state        | meaning
// -------------+-----------------------------------------------
// ST_IDLE      | no output, waiting for enable
// ST_ACTIVE    | tvalid high, presenting beat at (r_x, r_y)
// ST_LINE_GAP  | tvalid low for H_GAP cycles between lines
// ST_FRAME_GAP | tvalid low for FRAME_GAP cycles after a frame
module axis_video_pattern_gen
    import video_pkg::*;
#(
    parameter int WIDTH       = 1920,
    parameter int HEIGHT      = 1080,
    parameter int DATA_WIDTH  = 24,
    parameter int COORD_WIDTH = 16,
    parameter int H_GAP       = 0,
    parameter int FRAME_GAP   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [1:0]                pattern_sel,
    axis_video_pattern_gen_if.master  m_axis,
    output logic                      frame_done,
    output logic [15:0]               frame_count
);

    localparam int                     GAP_W      = 16;
    localparam logic [COORD_WIDTH-1:0] X_LAST     = COORD_WIDTH'(WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST     = COORD_WIDTH'(HEIGHT - 1);
    localparam bit                     HAS_HGAP   = (H_GAP > 0);
    localparam bit                     HAS_FGAP   = (FRAME_GAP > 0);
    localparam logic [GAP_W-1:0]       HGAP_INIT  = HAS_HGAP ? GAP_W'(H_GAP - 1) : '0;
    localparam logic [GAP_W-1:0]       FGAP_INIT  = HAS_FGAP ? GAP_W'(FRAME_GAP - 1) : '0;

    state_e                  r_state, w_state_next;
    logic [COORD_WIDTH-1:0]  r_x, r_y, w_x_next, w_y_next;
    logic [GAP_W-1:0]        r_gap, w_gap_next;
    pattern_e                r_sel, w_sel_next;
    logic                    r_tvalid, r_tlast, r_tuser, r_frame_done;
    logic [DATA_WIDTH-1:0]   r_tdata;
    logic [15:0]             r_frame_count;
    logic [23:0]             w_pixel;
    logic                    w_accept, w_x_end, w_y_end, w_load, w_sof, w_frame_end;

    assign w_accept = r_tvalid & m_axis.tready;
    assign w_x_end  = (r_x == X_LAST);
    assign w_y_end  = (r_y == Y_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:
                if (enable) w_state_next = ST_ACTIVE;
            ST_ACTIVE:
                if (w_accept && w_x_end) begin
                    if (w_y_end) begin
                        if (HAS_FGAP)    w_state_next = ST_FRAME_GAP;
                        else if (enable) w_state_next = ST_ACTIVE;
                        else             w_state_next = ST_IDLE;
                    end else if (HAS_HGAP) begin
                        w_state_next = ST_LINE_GAP;
                    end
                end
            ST_LINE_GAP:
                if (r_gap == '0) w_state_next = ST_ACTIVE;
            ST_FRAME_GAP:
                if (r_gap == '0) w_state_next = enable ? ST_ACTIVE : ST_IDLE;
            default:
                w_state_next = ST_IDLE;
        endcase
    end

    // x/y always hold the coordinate of the beat being presented next, so
    // during a gap they already point at the next line/frame start and the
    // pixel is simply loaded from them when the gap expires.
    always_comb begin
        w_x_next    = r_x;
        w_y_next    = r_y;
        w_gap_next  = r_gap;
        w_load      = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_x_next = '0;
                w_y_next = '0;
                w_load   = enable;
            end
            ST_ACTIVE:
                if (w_accept) begin
                    if (!w_x_end) begin
                        w_x_next = r_x + 1'b1;
                        w_load   = 1'b1;
                    end else if (w_y_end) begin
                        w_x_next    = '0;
                        w_y_next    = '0;
                        w_frame_end = 1'b1;
                        w_gap_next  = FGAP_INIT;
                        w_load      = !HAS_FGAP && enable;
                    end else begin
                        w_x_next   = '0;
                        w_y_next   = r_y + 1'b1;
                        w_gap_next = HGAP_INIT;
                        w_load     = !HAS_HGAP;
                    end
                end
            ST_LINE_GAP:
                if (r_gap == '0) w_load = 1'b1;
                else             w_gap_next = r_gap - 1'b1;
            ST_FRAME_GAP:
                if (r_gap == '0) w_load = enable;
                else             w_gap_next = r_gap - 1'b1;
            default: ;
        endcase
    end

    assign w_sof      = (w_x_next == '0) && (w_y_next == '0);
    // The pattern is sampled only as the first beat of a frame is loaded.
    assign w_sel_next = (w_load && w_sof) ? pattern_e'(pattern_sel) : r_sel;

    pattern_pixel #(
        .WIDTH       (WIDTH),
        .HEIGHT      (HEIGHT),
        .COORD_WIDTH (COORD_WIDTH)
    ) u_pixel (
        .i_x   (w_x_next),
        .i_y   (w_y_next),
        .i_sel (w_sel_next),
        .o_rgb (w_pixel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_gap         <= '0;
            r_sel         <= PAT_BARS;
            r_tvalid      <= 1'b0;
            r_tdata       <= '0;
            r_tlast       <= 1'b0;
            r_tuser       <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_x          <= w_x_next;
            r_y          <= w_y_next;
            r_gap        <= w_gap_next;
            r_sel        <= w_sel_next;
            r_tvalid     <= (w_state_next == ST_ACTIVE);
            r_frame_done <= w_frame_end;
            if (w_load) begin
                r_tdata <= w_pixel;
                r_tlast <= (w_x_next == X_LAST);
                r_tuser <= w_sof;
            end
            if (w_frame_end) r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_tlast;
    assign m_axis.tuser  = r_tuser;
    assign frame_done    = r_frame_done;
    assign frame_count   = r_frame_count;

endmodule
